pll_lock_sequencer: RTL and testbench

- Supervises the 3-output system PLL (100 / 28.571428 / 3.580562 MHz) and sequences the core reset from PLL lock status.
- Runs on the free-running 50 MHz reference, never on a PLL output.
- Drives the PLL's rst input, qualifies its locked output (synchronise, debounce, timeout/retry) and releases core_reset only after stable lock plus a hold period.
- Re-enters the sequence on lock loss or a user reset request.

---
 rtl/pll_lock_sequencer.sv | 161 ++++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
`timescale 1ns/1ps
// pll_lock_sequencer: supervises the system PLL from the free-running 50 MHz
// reference. Pulses the PLL reset, qualifies the asynchronous locked flag
// (two-flop synchroniser, debounce, timeout with retry) and releases
// core_reset only after a stable lock plus a hold period.
module pll_lock_sequencer #(
    parameter int PLL_RST_CYCLES = 8,
    parameter int LOCK_TIMEOUT   = 1048576,
    parameter int STABLE_CYCLES  = 1024,
    parameter int HOLD_CYCLES    = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pll_locked,
    input  logic       user_reset_req,
    output logic       pll_rst,
    output logic       core_reset,
    output logic       ready,
    output logic       lock_lost,
    output logic [3:0] retry_count,
    output logic [2:0] state_dbg
);

    localparam int MAX_AB = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CD = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
    localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW     = $clog2(MAX_P) + 1;

    localparam logic [CW-1:0] RST_LAST     = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST    = CW'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        PLL_RESET = 3'd0,
        WAIT_LOCK = 3'd1,
        STABILIZE = 3'd2,
        HOLD      = 3'd3,
        RUN       = 3'd4
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          lost_next;
    logic [3:0]    retry_next;
    logic          locked_p0;
    logic          locked_s;

    // Retry counter stops at its maximum instead of wrapping.
    function automatic logic [3:0] sat_inc(input logic [3:0] value);
        return (value == 4'hF) ? value : value + 4'd1;
    endfunction

    // Two-flop synchroniser for the asynchronous PLL lock flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            locked_p0 <= 1'b0;
            locked_s  <= 1'b0;
        end else begin
            locked_p0 <= pll_locked;
            locked_s  <= locked_p0;
        end
    end

    // State, counter and registered outputs decoded from the next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= PLL_RESET;
            cnt         <= '0;
            pll_rst     <= 1'b1;
            core_reset  <= 1'b1;
            ready       <= 1'b0;
            lock_lost   <= 1'b0;
            retry_count <= 4'd0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            pll_rst     <= (state_next == PLL_RESET);
            core_reset  <= (state_next != RUN);
            ready       <= (state_next == RUN);
            lock_lost   <= lost_next;
            retry_count <= retry_next;
        end
    end

    // Next-state logic; lock loss always wins over the user request.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        lost_next  = lock_lost;
        retry_next = retry_count;
        case (state)
            PLL_RESET: begin
                if (cnt == RST_LAST) begin
                    state_next = WAIT_LOCK;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_next = STABILIZE;
                    cnt_next   = '0;
                end else if (cnt == TIMEOUT_LAST) begin
                    state_next = PLL_RESET;
                    cnt_next   = '0;
                    retry_next = sat_inc(retry_count);
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            STABILIZE: begin
                if (!locked_s) begin
                    // A glitch restarts the lock wait without counting a retry.
                    state_next = WAIT_LOCK;
                    cnt_next   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_next = HOLD;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            HOLD: begin
                if (!locked_s) begin
                    state_next = WAIT_LOCK;
                    cnt_next   = '0;
                end else if (user_reset_req) begin
                    // Keep the core in reset until the request has been low
                    // for the full hold time.
                    cnt_next = '0;
                end else if (cnt == HOLD_LAST) begin
                    state_next = RUN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_next = PLL_RESET;
                    cnt_next   = '0;
                    lost_next  = 1'b1;
                end else if (user_reset_req) begin
                    state_next = HOLD;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = PLL_RESET;
                cnt_next   = '0;
            end
        endcase
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
`timescale 1ns/1ps
// Self-checking bench for pll_lock_sequencer: a reset/lock vector table,
// directed corner-case sequences and a randomized run, all compared against
// a countdown-based phase model.
module tb_pll_lock_sequencer;

    localparam int PRC = 4;
    localparam int LT  = 32;
    localparam int SC  = 8;
    localparam int HC  = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       pll_locked;
    logic       user_reset_req;
    logic       pll_rst;
    logic       core_reset;
    logic       ready;
    logic       lock_lost;
    logic [3:0] retry_count;
    logic [2:0] state_dbg;

    int checks = 0;
    int errors = 0;

    // Reference model: phase number, cycles remaining in the phase, sticky flags.
    int   m_phase = 0;
    int   m_left  = PRC;
    int   m_retry = 0;
    logic m_lost  = 1'b0;
    logic m_sync0 = 1'b0;
    logic m_sync1 = 1'b0;

    typedef struct {
        logic       r;
        logic       pl;
        logic       rq;
        logic       e_prst;
        logic       e_crst;
        logic       e_rdy;
        logic [2:0] e_st;
    } vec_t;

    vec_t vecs[20];

    always #10 clock = ~clock;

    pll_lock_sequencer #(
        .PLL_RST_CYCLES(PRC),
        .LOCK_TIMEOUT  (LT),
        .STABLE_CYCLES (SC),
        .HOLD_CYCLES   (HC)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .pll_locked    (pll_locked),
        .user_reset_req(user_reset_req),
        .pll_rst       (pll_rst),
        .core_reset    (core_reset),
        .ready         (ready),
        .lock_lost     (lock_lost),
        .retry_count   (retry_count),
        .state_dbg     (state_dbg)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of the reference model: locked_s is the raw input two edges old.
    task automatic model_step(input logic r, input logic pl, input logic rq);
        logic ls;
        if (r) begin
            m_phase = 0; m_left = PRC; m_retry = 0; m_lost = 1'b0;
            m_sync0 = 1'b0; m_sync1 = 1'b0;
        end else begin
            ls = m_sync1;
            m_sync1 = m_sync0;
            m_sync0 = pl;
            case (m_phase)
                0: begin
                    m_left--;
                    if (m_left == 0) begin m_phase = 1; m_left = LT; end
                end
                1: begin
                    if (ls) begin
                        m_phase = 2; m_left = SC;
                    end else begin
                        m_left--;
                        if (m_left == 0) begin
                            m_phase = 0; m_left = PRC;
                            if (m_retry < 15) m_retry++;
                        end
                    end
                end
                2: begin
                    if (!ls) begin
                        m_phase = 1; m_left = LT;
                    end else begin
                        m_left--;
                        if (m_left == 0) begin m_phase = 3; m_left = HC; end
                    end
                end
                3: begin
                    if (!ls) begin
                        m_phase = 1; m_left = LT;
                    end else if (rq) begin
                        m_left = HC;
                    end else begin
                        m_left--;
                        if (m_left == 0) m_phase = 4;
                    end
                end
                default: begin
                    if (!ls) begin
                        m_lost = 1'b1; m_phase = 0; m_left = PRC;
                    end else if (rq) begin
                        m_phase = 3; m_left = HC;
                    end
                end
            endcase
        end
    endtask

    task automatic check_model();
        check("model_pll_rst",    pll_rst,     m_phase == 0);
        check("model_core_reset", core_reset,  m_phase != 4);
        check("model_ready",      ready,       m_phase == 4);
        check("model_lock_lost",  lock_lost,   m_lost);
        check("model_retry",      retry_count, m_retry);
        check("model_state",      state_dbg,   m_phase);
    endtask

    task automatic tick(input logic r, input logic pl, input logic rq, input bit cmp);
        reset = r;
        pll_locked = pl;
        user_reset_req = rq;
        @(posedge clock);
        model_step(r, pl, rq);
        #1;
        if (cmp) check_model();
    endtask

    // Counts the remaining high cycles of a pll_rst pulse already seen high.
    task automatic pulse_len(input logic pl, output int len);
        len = 1;
        for (int i = 0; i < 50; i++) begin
            tick(1'b0, pl, 1'b0, 1'b1);
            if (pll_rst !== 1'b1) break;
            len++;
        end
    endtask

    task automatic wait_ready(input logic pl, input int bound, output int n);
        n = 0;
        while (ready !== 1'b1 && n < bound) begin
            tick(1'b0, pl, 1'b0, 1'b1);
            n++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int len;
        int highs;
        int rises[$];
        logic prev;
        logic saw;
        logic pl;
        logic rq;
        logic r;

        reset = 1'b1;
        pll_locked = 1'b0;
        user_reset_req = 1'b0;

        //            r  pl rq prst crst rdy st
        vecs[0]  = '{1, 0, 0, 1, 1, 0, 3'd0};
        vecs[1]  = '{0, 0, 0, 1, 1, 0, 3'd0};
        vecs[2]  = '{0, 0, 0, 1, 1, 0, 3'd0};
        vecs[3]  = '{0, 0, 0, 1, 1, 0, 3'd0};
        vecs[4]  = '{0, 0, 0, 0, 1, 0, 3'd1};
        vecs[5]  = '{0, 1, 0, 0, 1, 0, 3'd1};
        vecs[6]  = '{0, 1, 0, 0, 1, 0, 3'd1};
        vecs[7]  = '{0, 1, 0, 0, 1, 0, 3'd2};
        vecs[8]  = '{0, 1, 0, 0, 1, 0, 3'd2};
        vecs[9]  = '{0, 1, 0, 0, 1, 0, 3'd2};
        vecs[10] = '{0, 1, 0, 0, 1, 0, 3'd2};
        vecs[11] = '{0, 1, 0, 0, 1, 0, 3'd2};
        vecs[12] = '{0, 1, 0, 0, 1, 0, 3'd2};
        vecs[13] = '{0, 1, 0, 0, 1, 0, 3'd2};
        vecs[14] = '{0, 1, 0, 0, 1, 0, 3'd2};
        vecs[15] = '{0, 1, 0, 0, 1, 0, 3'd3};
        vecs[16] = '{0, 1, 0, 0, 1, 0, 3'd3};
        vecs[17] = '{0, 1, 0, 0, 1, 0, 3'd3};
        vecs[18] = '{0, 1, 0, 0, 1, 0, 3'd3};
        vecs[19] = '{0, 1, 0, 0, 0, 1, 3'd4};

        // Nominal lock: 4-cycle pll_rst, ready 15 edges after pll_locked rises.
        for (int i = 0; i < 20; i++) begin
            tick(vecs[i].r, vecs[i].pl, vecs[i].rq, 1'b0);
            check($sformatf("vec%0d_pll_rst", i),    pll_rst,    vecs[i].e_prst);
            check($sformatf("vec%0d_core_reset", i), core_reset, vecs[i].e_crst);
            check($sformatf("vec%0d_ready", i),      ready,      vecs[i].e_rdy);
            check($sformatf("vec%0d_state", i),      state_dbg,  vecs[i].e_st);
            check($sformatf("vec%0d_lock_lost", i),  lock_lost,  1'b0);
            check($sformatf("vec%0d_retry", i),      retry_count, 4'd0);
        end

        // Lock loss in RUN: core_reset within 3 cycles, 4-cycle PLL pulse.
        n = 0;
        do begin
            tick(1'b0, 1'b0, 1'b0, 1'b1);
            n++;
        end while (core_reset !== 1'b1 && n < 10);
        check("lockloss_latency", n, 3);
        check("lockloss_sticky", lock_lost, 1'b1);
        pulse_len(1'b0, len);
        check("lockloss_pulse_len", len, PRC);
        wait_ready(1'b1, 80, n);
        check("relock_ready", ready, 1'b1);
        check("relock_time", n, 2 + 1 + SC + HC);
        check("relock_lock_lost_kept", lock_lost, 1'b1);

        // User reset: 3-cycle request, core_reset until 4 cycles after it drops.
        saw = 1'b0;
        tick(1'b0, 1'b1, 1'b1, 1'b1);
        check("user_core_reset_next", core_reset, 1'b1);
        check("user_state_hold", state_dbg, 3'd3);
        tick(1'b0, 1'b1, 1'b1, 1'b1);
        if (pll_rst !== 1'b0) saw = 1'b1;
        tick(1'b0, 1'b1, 1'b1, 1'b1);
        if (pll_rst !== 1'b0) saw = 1'b1;
        n = 0;
        do begin
            tick(1'b0, 1'b1, 1'b0, 1'b1);
            if (pll_rst !== 1'b0) saw = 1'b1;
            n++;
        end while (core_reset === 1'b1 && n < 20);
        check("user_release_delay", n, HC);
        check("user_no_pll_rst", saw, 1'b0);
        check("user_lock_lost_kept", lock_lost, 1'b1);
        check("user_retry_kept", retry_count, 4'd0);

        // Same-cycle lock loss and user request: PLL reset path wins.
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1, 1'b1);
        check("same_cycle_state", state_dbg, 3'd0);
        check("same_cycle_pll_rst", pll_rst, 1'b1);

        // Reset, then timeout retries with no lock.
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        check("reset_clears_lock_lost", lock_lost, 1'b0);
        check("reset_pll_rst", pll_rst, 1'b1);
        highs = 1;
        prev = pll_rst;
        for (int i = 1; i <= 100; i++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b1);
            if (pll_rst === 1'b1) highs++;
            if (prev !== 1'b1 && pll_rst === 1'b1) rises.push_back(i);
            prev = pll_rst;
        end
        check("timeout_rise_count", rises.size(), 2);
        if (rises.size() >= 2) begin
            check("timeout_first_rise", rises[0], PRC + LT);
            check("timeout_spacing", rises[1] - rises[0], PRC + LT);
        end
        check("timeout_high_cycles", highs, 3 * PRC);
        check("timeout_retry2", retry_count, 4'd2);
        check("timeout_core_reset", core_reset, 1'b1);
        for (int i = 0; i < 600; i++) tick(1'b0, 1'b0, 1'b0, 1'b1);
        check("timeout_retry_sat", retry_count, 4'd15);

        // Reset during HOLD.
        n = 0;
        while (state_dbg !== 3'd3 && n < 100) begin
            tick(1'b0, 1'b1, 1'b0, 1'b1);
            n++;
        end
        check("reach_hold", state_dbg, 3'd3);
        tick(1'b1, 1'b1, 1'b0, 1'b1);
        check("midrst_pll_rst", pll_rst, 1'b1);
        check("midrst_core_reset", core_reset, 1'b1);
        check("midrst_ready", ready, 1'b0);
        check("midrst_retry", retry_count, 4'd0);
        check("midrst_state", state_dbg, 3'd0);
        pulse_len(1'b0, len);
        check("midrst_pulse_len", len, PRC);

        // Reset in the middle of a pll_rst pulse restarts the full pulse.
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        check("pulse_rst_state", state_dbg, 3'd0);
        pulse_len(1'b0, len);
        check("pulse_rst_len", len, PRC);

        // Glitchy lock: 5 high, 1 low, then high.
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'b0, 1'b1);
        check("glitch_stabilize", state_dbg, 3'd2);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        check("glitch_back_to_wait", state_dbg, 3'd1);
        check("glitch_no_retry", retry_count, 4'd0);
        wait_ready(1'b1, 40, n);
        check("glitch_ready_time", n + 2, 2 + 1 + SC + HC);

        // Randomized run against the model.
        pl = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) pl = ~pl;
            rq = ($urandom_range(0, 19) == 0);
            r  = ($urandom_range(0, 399) == 0);
            tick(r, pl, rq, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
